fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage, directly upstream of the register-select decoder.
//  Holds the word-addressed PC and issues one-outstanding requests to instruction memory.
//  Buffers returned 16-bit instructions in a 2-entry queue.
//  Presents them to decode over a valid/ready handshake; accepts branch/jump redirects.
// PARAMETERS
//  PC_W      16      PC and memory address width (word address, one 16-bit instr per word)
//  RESET_PC  16'h0   PC loaded on reset
//  QDEPTH    2       instruction queue entries (power of 2, >=2)
// PORTS
//  clk             in   1     single clock; all state updates on posedge
//  rst             in   1     reset, synchronous, active-high
//  imem_req        out  1     request valid; addr held stable until imem_ack
//  imem_addr       out  PC_W  word address of request
//  imem_ack        in   1     read data valid this cycle; >=1 cycle after req
//  imem_rdata      in   16    instruction word
//  redirect_valid  in   1     taken branch/jump from execute
//  redirect_pc     in   PC_W  new fetch address
//  instr_valid     out  1     instr/instr_pc valid for decode
//  instr_ready     in   1     decode accepts (transfer = valid & ready)
//  instr           out  16    instruction word to decode ([15:13] op, [12:10] ra, [9:7] rb, [2:0] rc)
//  instr_pc        out  PC_W  address of instr
//  perf_fetch_cnt  out  32    instructions delivered to decode (see CONFIGURATION)
//  perf_bubble_cnt out  32    cycles with instr_valid=0 after reset release
// BEHAVIOUR
//  Clock/reset: one clock; reset is synchronous and active-high.
//  Reset values: fetch_pc=RESET_PC, state=IDLE, queue empty.
//    Outputs: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, perf counters=0.
//  FSM: IDLE, WAIT, DROP.
//    IDLE: assert imem_req when free slots (QDEPTH - count - outstanding) > 0 -> WAIT.
//    WAIT: on imem_ack, push {imem_rdata, fetch_pc}; fetch_pc <= fetch_pc+1.
//      Same cycle: re-request if a slot remains, else -> IDLE.
//    DROP: outstanding req belongs to a squashed path; on imem_ack discard data -> IDLE.
//  First imem_req the cycle after reset deasserts.
//  Back-to-back fetch supported: ack in cycle N, next req visible in cycle N+1.
//  PC arithmetic: PC_W-bit, wraps 16'hFFFF -> 16'h0000, no flag.
//  Queue: FIFO. Output is the head entry, driven combinationally from registers.
//    Push and pop in the same cycle is allowed when full.
//  Redirect (highest priority):
//    Flush queue; instr_valid=0 next cycle; fetch_pc <= redirect_pc.
//    From IDLE -> IDLE; new req next cycle.
//    From WAIT without ack -> DROP.
//    From WAIT with same-cycle ack -> data discarded, -> IDLE.
//    From DROP -> stays DROP; PC updated.
//  Transfer on redirect cycle is still counted as taken by decode (decode squashes it).
//  rst during WAIT/DROP: returns to IDLE immediately.
//    A later stray imem_ack with state IDLE and no outstanding req is ignored.
//  Latency: redirect to first instr_valid = 2 cycles + memory latency.
// CONFIGURATION
//  FETCH_PERF_EN defined:
//    perf_fetch_cnt += 1 per valid&ready transfer.
//    perf_bubble_cnt += 1 per cycle with instr_valid=0 and rst=0.
//    Both 32-bit, wrap, cleared by rst.
//  Not defined: counters not built; both ports tied to 32'h0.
// STRUCTURE
//  cpu_defs.vh (shared with decoder/ALU): INSTR_W=16, NREG=8, field LSB/MSB localparams,
//    FETCH_IDLE/WAIT/DROP 2-bit state encodings.
//  Sub-module fetch_queue: QDEPTH-entry FIFO of {instr, pc}, ptr+count, flush input.
//  FSM, PC and perf counters live in fetch_unit.
// TESTING
//  1 Reset, 1-cycle-latency mem returning addr as data, ready=1
//    -> instr 0,1,2,3 with instr_pc 0,1,2,3 on consecutive cycles after fill.
//  2 ready=0 for 6 cycles -> queue fills at 2 entries, imem_req drops;
//    ready=1 -> order preserved, no loss or duplication.
//  3 Redirect to 16'h0040 while WAIT, ack 2 cycles later
//    -> that data dropped; first instr_pc after redirect = 16'h0040.
//  4 Redirect same cycle as ack -> no stale instr delivered; next fetch at redirect_pc.
//  5 Redirect to 16'hFFFE -> instr_pc FFFE, FFFF, 0000.
//  6 With FETCH_PERF_EN, 10 transfers + 3 bubble cycles -> counters read 10 and 3;
//    without macro -> both 0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions for fetch, decode and ALU: instruction geometry,
// register count, instruction field positions and fetch FSM states.
package fetch_unit_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned NREG    = 8;

  localparam int unsigned OP_MSB = 15;
  localparam int unsigned OP_LSB = 13;
  localparam int unsigned RA_MSB = 12;
  localparam int unsigned RA_LSB = 10;
  localparam int unsigned RB_MSB = 9;
  localparam int unsigned RB_LSB = 7;
  localparam int unsigned RC_MSB = 2;
  localparam int unsigned RC_LSB = 0;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of {instr, pc} pairs with synchronous flush; the head entry
// is presented combinationally from storage and reads as zero when empty.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PC_W  = 16,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic [PC_W-1:0]    push_pc,
  input  logic               pop,
  output logic               head_valid,
  output logic [INSTR_W-1:0] head_instr,
  output logic [PC_W-1:0]    head_pc,
  output logic [CNT_W-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               do_push;
  logic               do_pop;

  assign do_pop  = pop && (count != '0);
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        instr_mem[wr_ptr] <= push_instr;
        pc_mem[wr_ptr]    <= push_pc;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign head_valid = (count != '0);
  assign head_instr = head_valid ? instr_mem[rd_ptr] : '0;
  assign head_pc    = head_valid ? pc_mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem requests, redirect squash
// and a small instruction queue toward decode. Optional counters: FETCH_PERF_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     QDEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_bubble_cnt
);

  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

  fetch_state_e     state;
  fetch_state_e     state_nx;
  logic [PC_W-1:0]  fetch_pc;
  logic [PC_W-1:0]  fetch_pc_nx;
  logic [PC_W-1:0]  addr_q;
  logic             q_push;
  logic             q_flush;
  logic [CNT_W-1:0] q_count;
  logic             transfer;

  assign transfer = instr_valid && instr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH_IDLE;
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      addr_q   <= imem_addr;
    end
  end

  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    q_push      = 1'b0;
    q_flush     = 1'b0;
    imem_req    = 1'b0;
    imem_addr   = fetch_pc;
    case (state)
      FETCH_IDLE: begin
        // A fresh request is withheld on a redirect cycle so none is abandoned.
        imem_req = (q_count < CNT_W'(QDEPTH)) && !redirect_valid && !rst;
        if (imem_req) state_nx = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        imem_req = !rst;
        if (imem_ack) begin
          q_push      = 1'b1;
          fetch_pc_nx = fetch_pc + PC_W'(1);
          if ((q_count - CNT_W'(transfer)) >= CNT_W'(QDEPTH - 1)) state_nx = FETCH_IDLE;
        end
      end
      FETCH_DROP: begin
        imem_req  = !rst;
        imem_addr = addr_q;
        if (imem_ack) state_nx = FETCH_IDLE;
      end
      default: state_nx = FETCH_IDLE;
    endcase
    // Redirect overrides; DROP is left only once the squashed request is acked.
    if (redirect_valid) begin
      q_push      = 1'b0;
      q_flush     = 1'b1;
      fetch_pc_nx = redirect_pc;
      if ((state == FETCH_WAIT || state == FETCH_DROP) && !imem_ack) begin
        state_nx = FETCH_DROP;
      end else begin
        state_nx = FETCH_IDLE;
      end
    end
  end

  fetch_queue #(
    .DEPTH (QDEPTH),
    .PC_W  (PC_W)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (q_flush),
    .push       (q_push),
    .push_instr (imem_rdata),
    .push_pc    (fetch_pc),
    .pop        (transfer),
    .head_valid (instr_valid),
    .head_instr (instr),
    .head_pc    (instr_pc),
    .count      (q_count)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (transfer) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (!instr_valid) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`else
  assign perf_fetch_cnt  = '0;
  assign perf_bubble_cnt = '0;
`endif

endmodule
